// File: rtl/tl_txn_tracker.sv
// tl_txn_tracker: passive TileLink A/D channel monitor.
// Tracks every outstanding request per source ID, counts beats of multi-beat
// messages and latches the first protocol violation seen (sticky until
// clear_err). Optional build macro TL_TXN_TRACKER_DPI_EN adds a report
// on every error capture plus a 64-bit cycle counter for it.
//
// Entry states:
//   S_IDLE    | no request outstanding on this source
//   S_A_BURST | request accepted, remaining A beats > 0
//   S_PENDING | request complete, waiting for the D first beat
//   S_D_BURST | response started, remaining D beats > 0
module tl_txn_tracker #(
    parameter int SIZE_WD   = 3,
    parameter int SOURCE_WD = 4,
    parameter int DATA_WD   = 256,
    parameter int TIMEOUT   = 1000,
    parameter int TMR_WD    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2:0]           a_opcode,
    input  logic [SIZE_WD-1:0]   a_size,
    input  logic [SOURCE_WD-1:0] a_source,
    input  logic                 a_valid,
    input  logic                 a_ready,
    input  logic [2:0]           d_opcode,
    input  logic [SIZE_WD-1:0]   d_size,
    input  logic [SOURCE_WD-1:0] d_source,
    input  logic                 d_valid,
    input  logic                 d_ready,
    input  logic                 clear_err,
    output logic [SOURCE_WD:0]   outstanding,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [SOURCE_WD-1:0] err_source,
    output logic [31:0]          a_fire_cnt,
    output logic [31:0]          d_fire_cnt
);

    localparam int N      = 1 << SOURCE_WD;
    localparam int LOG_BB = $clog2(DATA_WD / 8);
    localparam int CNT_WD = SIZE_WD + 1;
    localparam logic [TMR_WD-1:0] TMO_MAX = TMR_WD'(TIMEOUT);
    localparam logic [TMR_WD-1:0] TMO_M1  = TMR_WD'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_A_BURST, S_PENDING, S_D_BURST} st_e;

    // Beats minus one for a message; non-data messages are always one beat.
    function automatic logic [CNT_WD-1:0] beats_m1(input logic data_op,
                                                   input logic [SIZE_WD-1:0] size);
        logic [CNT_WD-1:0] one;
        int sh;
        one = CNT_WD'(1);
        sh  = int'(size) - LOG_BB;
        return (data_op && sh > 0) ? (one << sh) - one : '0;
    endfunction

    function automatic logic resp_ok(input logic [2:0] a_op, input logic [2:0] d_op);
        case (a_op)
            3'd0, 3'd1:       return d_op == 3'd0;
            3'd2, 3'd3, 3'd4: return d_op == 3'd1;
            3'd5:             return d_op == 3'd2;
            default:          return (d_op == 3'd4) || (d_op == 3'd5);
        endcase
    endfunction

    logic a_fire, d_fire;
    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    logic [N-1:0]   busy_d;
    logic [N-1:0]   tmo_v;
    logic [3*N-1:0] a_err_v;
    logic [3*N-1:0] d_err_v;

    for (genvar i = 0; i < N; i++) begin : g_ent
        localparam logic [SOURCE_WD-1:0] IDX = SOURCE_WD'(i);
        st_e               st_q, st_d;
        logic [CNT_WD-1:0] cnt_q, cnt_d;
        logic [2:0]        op_q, op_d;
        logic [SIZE_WD-1:0] sz_q, sz_d;
        logic [TMR_WD-1:0] tmr_q, tmr_d;
        logic              to_q, to_d;
        logic              a_hit, d_hit, tmo;
        logic [2:0]        a_err, d_err;

        assign a_hit = a_fire && (a_source == IDX);
        assign d_hit = d_fire && (d_source == IDX);

        // Entry next state: D applied first, then A on the resulting state.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            op_d  = op_q;
            sz_d  = sz_q;
            tmr_d = '0;
            to_d  = 1'b0;
            a_err = 3'd0;
            d_err = 3'd0;
            tmo   = 1'b0;
            if (d_hit) begin
                case (st_q)
                    S_PENDING: begin
                        if (!resp_ok(op_q, d_opcode)) d_err = 3'd3;
                        op_d  = d_opcode;
                        sz_d  = d_size;
                        cnt_d = beats_m1((d_opcode == 3'd1) || (d_opcode == 3'd5), d_size);
                        st_d  = (cnt_d != '0) ? S_D_BURST : S_IDLE;
                    end
                    S_D_BURST: begin
                        if (d_opcode != op_q || d_size != sz_q) d_err = 3'd4;
                        cnt_d = cnt_q - CNT_WD'(1);
                        if (cnt_q == CNT_WD'(1)) st_d = S_IDLE;
                    end
                    default: d_err = 3'd2;
                endcase
            end
            if (a_hit) begin
                case (st_d)
                    S_IDLE: begin
                        op_d  = a_opcode;
                        sz_d  = a_size;
                        cnt_d = beats_m1(a_opcode <= 3'd3, a_size);
                        st_d  = (cnt_d != '0) ? S_A_BURST : S_PENDING;
                    end
                    S_A_BURST: begin
                        if (a_opcode != op_q || a_size != sz_q) a_err = 3'd4;
                        cnt_d = cnt_q - CNT_WD'(1);
                        if (cnt_q == CNT_WD'(1)) st_d = S_PENDING;
                    end
                    default: a_err = 3'd1;
                endcase
            end
            if (st_q == S_PENDING && !d_hit) begin
                tmr_d = (tmr_q == TMO_MAX) ? tmr_q : tmr_q + TMR_WD'(1);
                tmo   = (tmr_q == TMO_M1) && !to_q;
                to_d  = to_q | tmo;
            end
        end

        // Entry registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                op_q  <= '0;
                sz_q  <= '0;
                tmr_q <= '0;
                to_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                op_q  <= op_d;
                sz_q  <= sz_d;
                tmr_q <= tmr_d;
                to_q  <= to_d;
            end
        end

        assign busy_d[i]        = (st_d != S_IDLE);
        assign tmo_v[i]         = tmo;
        assign a_err_v[3*i +: 3] = a_err;
        assign d_err_v[3*i +: 3] = d_err;
    end

    logic [2:0]           a_code, d_code, new_code;
    logic [SOURCE_WD-1:0] tmo_src, new_src;
    logic                 new_err, capture;
    logic [SOURCE_WD:0]   out_d, out_q;

    // Merge per-entry errors: lowest code wins, A beats D on a tie.
    always_comb begin
        a_code  = 3'd0;
        d_code  = 3'd0;
        tmo_src = '0;
        out_d   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            a_code = a_code | a_err_v[3*k +: 3];
            d_code = d_code | d_err_v[3*k +: 3];
            if (tmo_v[k]) tmo_src = SOURCE_WD'(k);
            out_d = out_d + (SOURCE_WD+1)'(busy_d[k]);
        end
        new_err  = 1'b1;
        new_code = 3'd0;
        new_src  = '0;
        if (a_code != 3'd0 && (d_code == 3'd0 || a_code <= d_code)) begin
            new_code = a_code;
            new_src  = a_source;
        end else if (d_code != 3'd0) begin
            new_code = d_code;
            new_src  = d_source;
        end else if (tmo_v != '0) begin
            new_code = 3'd5;
            new_src  = tmo_src;
        end else begin
            new_err = 1'b0;
        end
    end

    logic                 err_valid_q, err_valid_d;
    logic [2:0]           err_code_q, err_code_d;
    logic [SOURCE_WD-1:0] err_source_q, err_source_d;
    logic [31:0]          a_fire_cnt_q, a_fire_cnt_d, d_fire_cnt_q, d_fire_cnt_d;

    assign capture = new_err && (!err_valid_q || clear_err);

    // Sticky first-error capture; a new error beats a same-cycle clear.
    always_comb begin
        err_valid_d  = err_valid_q;
        err_code_d   = err_code_q;
        err_source_d = err_source_q;
        if (capture) begin
            err_valid_d  = 1'b1;
            err_code_d   = new_code;
            err_source_d = new_src;
        end else if (clear_err) begin
            err_valid_d  = 1'b0;
            err_code_d   = 3'd0;
            err_source_d = '0;
        end
        a_fire_cnt_d = a_fire_cnt_q + 32'(a_fire);
        d_fire_cnt_d = d_fire_cnt_q + 32'(d_fire);
    end

    // Status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid_q  <= 1'b0;
            err_code_q   <= 3'd0;
            err_source_q <= '0;
            out_q        <= '0;
            a_fire_cnt_q <= '0;
            d_fire_cnt_q <= '0;
        end else begin
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_source_q <= err_source_d;
            out_q        <= out_d;
            a_fire_cnt_q <= a_fire_cnt_d;
            d_fire_cnt_q <= d_fire_cnt_d;
        end
    end

    assign outstanding = out_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign err_source  = err_source_q;
    assign a_fire_cnt  = a_fire_cnt_q;
    assign d_fire_cnt  = d_fire_cnt_q;

`ifdef TL_TXN_TRACKER_DPI_EN
    logic [63:0] cyc_q, cyc_d;
    assign cyc_d = cyc_q + 64'd1;

    // Free-running cycle stamp for error reports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc_q <= '0;
        else          cyc_q <= cyc_d;
    end

    // Report each captured error to the environment.
    always @(posedge clock) begin
        if (reset_n && capture)
            $display("tl_tracker_report code=%0d source=%0d cycle=%0d",
                     new_code, 32'(new_src), cyc_q);
    end
`endif

endmodule

// File: tb/tb_tl_txn_tracker.sv
// Directed testbench for tl_txn_tracker (DATA_WD 256, TIMEOUT 20).
module tb_tl_txn_tracker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  a_opcode = '0, d_opcode = '0;
    logic [2:0]  a_size = '0, d_size = '0;
    logic [3:0]  a_source = '0, d_source = '0;
    logic        a_valid = 1'b0, a_ready = 1'b0, d_valid = 1'b0, d_ready = 1'b0;
    logic        clear_err = 1'b0;
    logic [4:0]  outstanding;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [3:0]  err_source;
    logic [31:0] a_fire_cnt, d_fire_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    tl_txn_tracker #(
        .SIZE_WD(3), .SOURCE_WD(4), .DATA_WD(256), .TIMEOUT(20), .TMR_WD(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .d_valid(d_valid), .d_ready(d_ready),
        .clear_err(clear_err), .outstanding(outstanding),
        .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
        .a_fire_cnt(a_fire_cnt), .d_fire_cnt(d_fire_cnt)
    );

    typedef struct {
        logic av; logic ar; logic [2:0] aop; logic [2:0] asz; logic [3:0] asrc;
        logic dv; logic [2:0] dop; logic [2:0] dsz; logic [3:0] dsrc;
        logic clr;
        int out; logic ev; logic [2:0] ec; logic [3:0] es; int afc; int dfc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic av, ar, input int aop, asz, asrc,
                                input logic dv, input int dop, dsz, dsrc,
                                input logic clr, input int out, input logic ev,
                                input int ec, es, afc, dfc);
        vec_t v;
        v.av = av; v.ar = ar; v.aop = 3'(aop); v.asz = 3'(asz); v.asrc = 4'(asrc);
        v.dv = dv; v.dop = 3'(dop); v.dsz = 3'(dsz); v.dsrc = 4'(dsrc);
        v.clr = clr; v.out = out; v.ev = ev; v.ec = 3'(ec); v.es = 4'(es);
        v.afc = afc; v.dfc = dfc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Drive one cycle of stimulus at the falling edge, sample 1 after rising edge.
    task automatic drive(input vec_t v);
        @(negedge clock);
        a_valid = v.av; a_ready = v.ar; a_opcode = v.aop; a_size = v.asz; a_source = v.asrc;
        d_valid = v.dv; d_ready = 1'b1; d_opcode = v.dop; d_size = v.dsz; d_source = v.dsrc;
        clear_err = v.clr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(mk(0,1,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0));
    endtask

    task automatic chk_state(input string nm, input int out, input logic ev,
                             input int ec, input int es);
        chk({nm, "_out"}, 32'(outstanding), 32'(out));
        chk({nm, "_ev"},  32'(err_valid),   32'(ev));
        chk({nm, "_ec"},  32'(err_code),    32'(ec));
        chk({nm, "_es"},  32'(err_source),  32'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int k;
        //          av ar aop asz asrc dv dop dsz dsrc clr out ev ec es afc dfc
        tbl.push_back(mk(1,1,4,6,3,  0,0,0,0,  0, 1,0,0,0,  1,0));   // Get s6 src3
        tbl.push_back(mk(0,1,0,0,0,  1,1,6,3,  0, 1,0,0,0,  1,1));   // AckData beat 1
        tbl.push_back(mk(0,1,0,0,0,  1,1,6,3,  0, 0,0,0,0,  1,2));   // AckData beat 2
        tbl.push_back(mk(1,1,0,6,5,  0,0,0,0,  0, 1,0,0,0,  2,2));   // PutFull beat 1
        tbl.push_back(mk(1,1,0,6,5,  0,0,0,0,  0, 1,0,0,0,  3,2));   // PutFull beat 2
        tbl.push_back(mk(0,1,0,0,0,  1,0,6,5,  0, 0,0,0,0,  3,3));   // AccessAck
        tbl.push_back(mk(1,0,4,0,9,  0,0,0,0,  0, 0,0,0,0,  3,3));   // valid, not ready
        tbl.push_back(mk(1,1,4,0,2,  0,0,0,0,  0, 1,0,0,0,  4,3));   // Get src2
        tbl.push_back(mk(1,1,4,0,2,  0,0,0,0,  0, 1,1,1,2,  5,3));   // dup Get src2
        tbl.push_back(mk(0,1,0,0,0,  1,1,0,2,  0, 0,1,1,2,  5,4));   // response, sticky err
        tbl.push_back(mk(0,1,0,0,0,  1,0,0,7,  0, 0,1,1,2,  5,5));   // orphan, first kept
        tbl.push_back(mk(0,1,0,0,0,  0,0,0,0,  1, 0,0,0,0,  5,5));   // clear
        tbl.push_back(mk(0,1,0,0,0,  1,0,0,7,  0, 0,1,2,7,  5,6));   // orphan src7
        tbl.push_back(mk(0,1,0,0,0,  0,0,0,0,  1, 0,0,0,0,  5,6));   // clear
        tbl.push_back(mk(1,1,4,0,1,  0,0,0,0,  0, 1,0,0,0,  6,6));   // Get src1
        tbl.push_back(mk(0,1,0,0,0,  1,0,0,1,  0, 0,1,3,1,  6,7));   // wrong resp op
        tbl.push_back(mk(1,1,4,0,6,  0,0,0,0,  1, 1,0,0,0,  7,7));   // clear + Get src6
        tbl.push_back(mk(1,1,4,0,6,  1,0,0,8,  1, 1,1,1,6,  8,8));   // dup+orphan+clear
        tbl.push_back(mk(0,1,0,0,0,  1,1,0,6,  1, 0,0,0,0,  8,9));   // clear + response
        tbl.push_back(mk(1,1,4,6,11, 0,0,0,0,  0, 1,0,0,0,  9,9));   // Get s6 src11
        tbl.push_back(mk(1,1,0,6,10, 1,1,6,11, 0, 2,0,0,0,  10,10)); // PutFull b1 + AckData b1
        tbl.push_back(mk(1,1,1,6,10, 1,1,5,11, 0, 1,1,4,10, 11,11)); // burst errs both, A wins
        tbl.push_back(mk(0,1,0,0,0,  1,0,0,10, 1, 0,0,0,0,  11,12)); // clear + AccessAck
        tbl.push_back(mk(1,1,0,6,12, 0,0,0,0,  0, 1,0,0,0,  12,12)); // PutFull b1 src12
        tbl.push_back(mk(1,1,0,7,12, 1,0,0,13, 0, 1,1,2,13, 13,13)); // burst(4) vs orphan(2)
        tbl.push_back(mk(0,1,0,0,0,  1,0,0,12, 1, 0,0,0,0,  13,14)); // clear + AccessAck
        tbl.push_back(mk(1,1,4,0,14, 0,0,0,0,  0, 1,0,0,0,  14,14)); // Get src14
        tbl.push_back(mk(1,1,4,0,14, 1,1,0,14, 0, 1,0,0,0,  15,15)); // D last + new A same src
        tbl.push_back(mk(0,1,0,0,0,  1,1,0,14, 0, 0,0,0,0,  15,16)); // response

        // Reset values.
        #12;
        chk_state("reset", 0, 1'b0, 0, 0);
        chk("reset_afc", a_fire_cnt, 32'd0);
        chk("reset_dfc", d_fire_cnt, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            chk_state($sformatf("v%0d", i), tbl[i].out, tbl[i].ev, 32'(tbl[i].ec), 32'(tbl[i].es));
            chk($sformatf("v%0d_afc", i), a_fire_cnt, 32'(tbl[i].afc));
            chk($sformatf("v%0d_dfc", i), d_fire_cnt, 32'(tbl[i].dfc));
        end

        // Timeout: Get on src4, never answered.
        drive(mk(1,1,4,0,4, 0,0,0,0, 0, 0,0,0,0, 0,0));
        k = 0;
        while (!err_valid && k < 100) begin
            idle();
            k++;
        end
        chk("tmo_cycles", 32'(k), 32'd20);
        chk_state("tmo", 1, 1'b1, 5, 4);
        repeat (30) idle();
        drive(mk(0,1,0,0,0, 0,0,0,0, 1, 0,0,0,0, 0,0));
        repeat (5) idle();
        chk_state("tmo_no_rearm", 1, 1'b0, 0, 0);
        drive(mk(0,1,0,0,0, 1,1,0,4, 0, 0,0,0,0, 0,0));
        chk_state("tmo_late_resp", 0, 1'b0, 0, 0);

        // Async reset in the middle of a D burst with 3 outstanding.
        drive(mk(1,1,4,6,1, 0,0,0,0, 0, 0,0,0,0, 0,0));
        drive(mk(1,1,4,6,2, 0,0,0,0, 0, 0,0,0,0, 0,0));
        drive(mk(1,1,4,6,3, 0,0,0,0, 0, 0,0,0,0, 0,0));
        drive(mk(0,1,0,0,0, 1,1,6,1, 0, 0,0,0,0, 0,0));
        drive(mk(0,1,0,0,0, 1,0,0,9, 0, 0,0,0,0, 0,0));
        chk_state("pre_rst", 3, 1'b1, 2, 9);
        @(negedge clock);
        a_valid = 1'b0; d_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_state("mid_rst", 0, 1'b0, 0, 0);
        chk("mid_rst_afc", a_fire_cnt, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(mk(1,1,4,0,3, 0,0,0,0, 0, 0,0,0,0, 0,0));
        chk_state("post_rst_a", 1, 1'b0, 0, 0);
        drive(mk(0,1,0,0,0, 1,1,0,3, 0, 0,0,0,0, 0,0));
        chk_state("post_rst_d", 0, 1'b0, 0, 0);
        chk("post_rst_dfc", d_fire_cnt, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
